// File: rtl/tri_setup_pkg.sv
// Shared widths, vertex field layout, FSM encodings and small helpers for the
// triangle setup stage.
package tri_setup_pkg;

    localparam int COORD_W = 16;
    localparam int VTX_W   = 3 * COORD_W;
    localparam int TRI_W   = 9 * COORD_W;
    localparam int X_OFF   = 0;
    localparam int Y_OFF   = COORD_W;
    localparam int Z_OFF   = 2 * COORD_W;

    localparam int AB_W    = COORD_W + 1;
    localparam int PROD_W  = 2 * COORD_W;
    localparam int C_W     = 2 * COORD_W + 1;
    localparam int AREA_W  = 2 * COORD_W + 3;

    typedef logic signed [COORD_W-1:0] coord_t;
    typedef logic signed [AB_W-1:0]    ab_t;
    typedef logic signed [PROD_W-1:0]  prod_t;
    typedef logic signed [C_W-1:0]     c_t;
    typedef logic signed [AREA_W-1:0]  area_t;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_MUL   = 3'd2;
    localparam logic [2:0] ST_SUM   = 3'd3;
    localparam logic [2:0] ST_OUT   = 3'd4;
    localparam logic [2:0] ST_REARM = 3'd5;

    localparam logic [2:0] STEP_LAST = 3'd5;

    function automatic coord_t field(input logic [TRI_W-1:0] w, input int vtx, input int off);
        return w[vtx*VTX_W + off +: COORD_W];
    endfunction

    function automatic coord_t min3(input coord_t a, input coord_t b, input coord_t c);
        coord_t m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic coord_t max3(input coord_t a, input coord_t b, input coord_t c);
        coord_t m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    function automatic ab_t sx_ab(input coord_t v);
        return {v[COORD_W-1], v};
    endfunction

    function automatic c_t sx_c(input prod_t v);
        return {v[PROD_W-1], v};
    endfunction

    function automatic area_t sx_area(input c_t v);
        return {{2{v[C_W-1]}}, v};
    endfunction

endpackage

// File: rtl/tri_setup_if.sv
// Deserializer/rasterizer-facing bundle of the triangle setup stage.
interface tri_setup_if;
    import tri_setup_pkg::*;

    logic               sipo_done;
    logic [TRI_W-1:0]   tri_in;
    logic               valid_data;
    logic               out_valid;
    logic               out_ready;
    coord_t             xmin, xmax, ymin, ymax;
    ab_t                a0, a1, a2, b0, b1, b2;
    c_t                 c0, c1, c2;
    area_t              area2;
    coord_t             z0, z1, z2;
    logic [7:0]         drop_cnt;

    modport master (
        output sipo_done, tri_in, out_ready,
        input  valid_data, out_valid, xmin, xmax, ymin, ymax,
               a0, a1, a2, b0, b1, b2, c0, c1, c2, area2, z0, z1, z2, drop_cnt
    );

    modport slave (
        input  sipo_done, tri_in, out_ready,
        output valid_data, out_valid, xmin, xmax, ymin, ymax,
               a0, a1, a2, b0, b1, b2, c0, c1, c2, area2, z0, z1, z2, drop_cnt
    );

endinterface

// File: rtl/tri_setup_bbox.sv
// Combinational signed three-way min/max of the vertex x and y coordinates.
module tri_bbox
    import tri_setup_pkg::*;
(
    input  coord_t x0_i,
    input  coord_t x1_i,
    input  coord_t x2_i,
    input  coord_t y0_i,
    input  coord_t y1_i,
    input  coord_t y2_i,
    output coord_t xmin_o,
    output coord_t xmax_o,
    output coord_t ymin_o,
    output coord_t ymax_o
);

    assign xmin_o = min3(x0_i, x1_i, x2_i);
    assign xmax_o = max3(x0_i, x1_i, x2_i);
    assign ymin_o = min3(y0_i, y1_i, y2_i);
    assign ymax_o = max3(y0_i, y1_i, y2_i);

endmodule

// File: rtl/tri_setup.sv
// Triangle setup: bounding box, edge coefficients and doubled signed area from
// one captured triangle, using a single multiplier time-shared over six cycles.
module tri_setup
    import tri_setup_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    tri_setup_if.slave  bus
);

    logic [2:0] state_q, state_d;
    logic [2:0] step_q;

    coord_t fx[3], fy[3], fz[3];
    coord_t x_q[3], y_q[3], z_q[3];
    ab_t    a_w[3], b_w[3], a_q[3], b_q[3];
    coord_t bb_w[4], bb_q[4];
    c_t     c_q[3];
    coord_t mul_a, mul_b;
    prod_t  prod_w, prod_q;
    c_t     diff_w;
    area_t  area_w;

    coord_t     bb_out_q[4];
    ab_t        a_out_q[3], b_out_q[3];
    c_t         c_out_q[3];
    coord_t     z_out_q[3];
    area_t      area_out_q;
    logic [7:0] drop_q;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_vtx
            assign fx[gi]  = field(bus.tri_in, gi, X_OFF);
            assign fy[gi]  = field(bus.tri_in, gi, Y_OFF);
            assign fz[gi]  = field(bus.tri_in, gi, Z_OFF);
            // Edge gi runs from vertex gi to vertex (gi+1)%3.
            assign a_w[gi] = sx_ab(y_q[gi]) - sx_ab(y_q[(gi+1)%3]);
            assign b_w[gi] = sx_ab(x_q[(gi+1)%3]) - sx_ab(x_q[gi]);
        end
    endgenerate

    tri_bbox u_bbox (
        .x0_i   (x_q[0]),
        .x1_i   (x_q[1]),
        .x2_i   (x_q[2]),
        .y0_i   (y_q[0]),
        .y1_i   (y_q[1]),
        .y2_i   (y_q[2]),
        .xmin_o (bb_w[0]),
        .xmax_o (bb_w[1]),
        .ymin_o (bb_w[2]),
        .ymax_o (bb_w[3])
    );

    // Even steps produce xa*yb, odd steps xb*ya; the pair difference is Ck.
    always_comb begin
        mul_a = x_q[0];
        mul_b = y_q[1];
        case (step_q)
            3'd1:    begin mul_a = x_q[1]; mul_b = y_q[0]; end
            3'd2:    begin mul_a = x_q[1]; mul_b = y_q[2]; end
            3'd3:    begin mul_a = x_q[2]; mul_b = y_q[1]; end
            3'd4:    begin mul_a = x_q[2]; mul_b = y_q[0]; end
            3'd5:    begin mul_a = x_q[0]; mul_b = y_q[2]; end
            default: ;
        endcase
    end

    assign prod_w = mul_a * mul_b;
    assign diff_w = sx_c(prod_q) - sx_c(prod_w);
    assign area_w = sx_area(c_q[0]) + sx_area(c_q[1]) + sx_area(c_q[2]);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.sipo_done) state_d = ST_SETUP;
            ST_SETUP: state_d = ST_MUL;
            ST_MUL:   if (step_q == STEP_LAST) state_d = ST_SUM;
            ST_SUM:   state_d = (area_w == '0) ? ST_REARM : ST_OUT;
            ST_OUT:   if (bus.out_ready) state_d = ST_REARM;
            ST_REARM: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            step_q     <= '0;
            prod_q     <= '0;
            area_out_q <= '0;
            drop_q     <= '0;
            for (int i = 0; i < 3; i++) begin
                x_q[i]     <= '0;
                y_q[i]     <= '0;
                z_q[i]     <= '0;
                a_q[i]     <= '0;
                b_q[i]     <= '0;
                c_q[i]     <= '0;
                a_out_q[i] <= '0;
                b_out_q[i] <= '0;
                c_out_q[i] <= '0;
                z_out_q[i] <= '0;
            end
            for (int i = 0; i < 4; i++) begin
                bb_q[i]     <= '0;
                bb_out_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && bus.sipo_done) begin
                x_q <= fx;
                y_q <= fy;
                z_q <= fz;
            end
            if (state_q == ST_SETUP) begin
                a_q    <= a_w;
                b_q    <= b_w;
                bb_q   <= bb_w;
                step_q <= '0;
            end
            if (state_q == ST_MUL) begin
                step_q <= step_q + 3'd1;
                if (!step_q[0]) begin
                    prod_q <= prod_w;
                end else begin
                    case (step_q[2:1])
                        2'd0:    c_q[0] <= diff_w;
                        2'd1:    c_q[1] <= diff_w;
                        default: c_q[2] <= diff_w;
                    endcase
                end
            end
            // Results only reach the outputs for non-degenerate triangles.
            if (state_q == ST_SUM) begin
                if (area_w == '0) begin
                    if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
                end else begin
                    bb_out_q   <= bb_q;
                    a_out_q    <= a_q;
                    b_out_q    <= b_q;
                    c_out_q    <= c_q;
                    z_out_q    <= z_q;
                    area_out_q <= area_w;
                end
            end
        end
    end

    assign bus.out_valid  = (state_q == ST_OUT);
    assign bus.valid_data = (state_q == ST_REARM);
    assign bus.xmin       = bb_out_q[0];
    assign bus.xmax       = bb_out_q[1];
    assign bus.ymin       = bb_out_q[2];
    assign bus.ymax       = bb_out_q[3];
    assign bus.a0         = a_out_q[0];
    assign bus.a1         = a_out_q[1];
    assign bus.a2         = a_out_q[2];
    assign bus.b0         = b_out_q[0];
    assign bus.b1         = b_out_q[1];
    assign bus.b2         = b_out_q[2];
    assign bus.c0         = c_out_q[0];
    assign bus.c1         = c_out_q[1];
    assign bus.c2         = c_out_q[2];
    assign bus.area2      = area_out_q;
    assign bus.z0         = z_out_q[0];
    assign bus.z1         = z_out_q[1];
    assign bus.z2         = z_out_q[2];
    assign bus.drop_cnt   = drop_q;

endmodule

// File: tb/tb_tri_setup.sv
// Directed bench for tri_setup: expected setup results are modelled from the
// vertex coordinates, queued at stimulus time and compared when the DUT responds.
module tb_tri_setup;
    import tri_setup_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tri_setup_if u_if ();

    tri_setup u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    typedef struct {
        bit     degen;
        longint xmin, xmax, ymin, ymax;
        longint a0, a1, a2, b0, b1, b2, c0, c1, c2;
        longint area, z0, z1, z2;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   errors   = 0;
    int   exp_drop = 0;

    task automatic chk(input string tag, input longint obs, input longint expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Model the triangle, optionally queue the expectation, and pulse sipo_done.
    task automatic drive_tri(input int x0, input int y0, input int z0,
                             input int x1, input int y1, input int z1,
                             input int x2, input int y2, input int z2,
                             input bit keep);
        longint xl[3], yl[3], zl[3], a[3], b[3], c[3];
        logic [TRI_W-1:0] w;
        exp_t e;
        xl[0] = x0; xl[1] = x1; xl[2] = x2;
        yl[0] = y0; yl[1] = y1; yl[2] = y2;
        zl[0] = z0; zl[1] = z1; zl[2] = z2;
        for (int k = 0; k < 3; k++) begin
            int nb;
            nb   = (k + 1) % 3;
            a[k] = yl[k] - yl[nb];
            b[k] = xl[nb] - xl[k];
            c[k] = xl[k] * yl[nb] - xl[nb] * yl[k];
        end
        e.xmin = xl[0]; e.xmax = xl[0]; e.ymin = yl[0]; e.ymax = yl[0];
        for (int k = 1; k < 3; k++) begin
            if (xl[k] < e.xmin) e.xmin = xl[k];
            if (xl[k] > e.xmax) e.xmax = xl[k];
            if (yl[k] < e.ymin) e.ymin = yl[k];
            if (yl[k] > e.ymax) e.ymax = yl[k];
        end
        e.a0 = a[0]; e.a1 = a[1]; e.a2 = a[2];
        e.b0 = b[0]; e.b1 = b[1]; e.b2 = b[2];
        e.c0 = c[0]; e.c1 = c[1]; e.c2 = c[2];
        e.area  = c[0] + c[1] + c[2];
        e.z0 = zl[0]; e.z1 = zl[1]; e.z2 = zl[2];
        e.degen = (e.area == 0);
        if (keep) begin
            sb.push_back(e);
            if (e.degen && exp_drop < 255) exp_drop++;
        end
        w = '0;
        for (int k = 0; k < 3; k++) begin
            w[k*VTX_W + X_OFF +: COORD_W] = 16'(xl[k]);
            w[k*VTX_W + Y_OFF +: COORD_W] = 16'(yl[k]);
            w[k*VTX_W + Z_OFF +: COORD_W] = 16'(zl[k]);
        end
        @(negedge clk);
        u_if.tri_in    = w;
        u_if.sipo_done = 1'b1;
        @(negedge clk);
        u_if.sipo_done = 1'b0;
    endtask

    task automatic check_out(input string n, input exp_t e);
        chk({n, ".xmin"},  longint'(u_if.xmin),  e.xmin);
        chk({n, ".xmax"},  longint'(u_if.xmax),  e.xmax);
        chk({n, ".ymin"},  longint'(u_if.ymin),  e.ymin);
        chk({n, ".ymax"},  longint'(u_if.ymax),  e.ymax);
        chk({n, ".a0"},    longint'(u_if.a0),    e.a0);
        chk({n, ".a1"},    longint'(u_if.a1),    e.a1);
        chk({n, ".a2"},    longint'(u_if.a2),    e.a2);
        chk({n, ".b0"},    longint'(u_if.b0),    e.b0);
        chk({n, ".b1"},    longint'(u_if.b1),    e.b1);
        chk({n, ".b2"},    longint'(u_if.b2),    e.b2);
        chk({n, ".c0"},    longint'(u_if.c0),    e.c0);
        chk({n, ".c1"},    longint'(u_if.c1),    e.c1);
        chk({n, ".c2"},    longint'(u_if.c2),    e.c2);
        chk({n, ".area2"}, longint'(u_if.area2), e.area);
        chk({n, ".z0"},    longint'(u_if.z0),    e.z0);
        chk({n, ".z1"},    longint'(u_if.z1),    e.z1);
        chk({n, ".z2"},    longint'(u_if.z2),    e.z2);
    endtask

    // hold = number of cycles out_ready stays low once out_valid is seen.
    task automatic run_tri(input string n,
                           input int x0, input int y0, input int z0,
                           input int x1, input int y1, input int z1,
                           input int x2, input int y2, input int z2,
                           input int hold);
        exp_t e;
        int   k;
        u_if.out_ready = (hold == 0);
        drive_tri(x0, y0, z0, x1, y1, z1, x2, y2, z2, 1'b1);
        k = 0;
        while (k < 40 && !u_if.out_valid && !u_if.valid_data) begin
            @(negedge clk);
            k++;
        end
        chk({n, ".latency"}, k, 8);
        e = sb.pop_front();
        if (k == 40) return;
        if (e.degen) begin
            chk({n, ".out_valid"},  longint'(u_if.out_valid), 0);
            chk({n, ".valid_data"}, longint'(u_if.valid_data), 1);
            chk({n, ".drop_cnt"},   longint'(u_if.drop_cnt), exp_drop);
            @(negedge clk);
            chk({n, ".valid_data_end"}, longint'(u_if.valid_data), 0);
            chk({n, ".out_valid_end"},  longint'(u_if.out_valid), 0);
        end else begin
            chk({n, ".out_valid"},  longint'(u_if.out_valid), 1);
            chk({n, ".valid_data"}, longint'(u_if.valid_data), 0);
            check_out(n, e);
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                // A stray sipo_done with different data while OUT must be ignored.
                if (i == 5) begin
                    u_if.tri_in    = ~u_if.tri_in;
                    u_if.sipo_done = 1'b1;
                end
                if (i == 6) u_if.sipo_done = 1'b0;
                chk({n, ".hold_valid"}, longint'(u_if.out_valid), 1);
                chk({n, ".hold_rearm"}, longint'(u_if.valid_data), 0);
                check_out({n, ".hold"}, e);
            end
            u_if.sipo_done = 1'b0;
            u_if.out_ready = 1'b1;
            @(negedge clk);
            chk({n, ".rearm"},       longint'(u_if.valid_data), 1);
            chk({n, ".valid_drop"},  longint'(u_if.out_valid), 0);
            @(negedge clk);
            chk({n, ".rearm_end"},   longint'(u_if.valid_data), 0);
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int ev;
        rst            = 1'b1;
        u_if.sipo_done = 1'b0;
        u_if.tri_in    = '0;
        u_if.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset.out_valid",  longint'(u_if.out_valid), 0);
        chk("reset.valid_data", longint'(u_if.valid_data), 0);
        chk("reset.drop_cnt",   longint'(u_if.drop_cnt), 0);
        chk("reset.area2",      longint'(u_if.area2), 0);
        chk("reset.c1",         longint'(u_if.c1), 0);
        chk("reset.xmax",       longint'(u_if.xmax), 0);
        rst = 1'b0;

        run_tri("right", 0, 0, 5, 10, 0, 6, 0, 10, 7, 0);
        chk("right.area_abs", longint'(u_if.area2), 100);
        chk("right.c1_abs",   longint'(u_if.c1), 100);

        run_tri("neg", -5, -5, 1, 5, -5, 2, 0, 5, 3, 0);
        chk("neg.area_abs", longint'(u_if.area2), 100);
        chk("neg.xmin_abs", longint'(u_if.xmin), -5);
        chk("neg.ymin_abs", longint'(u_if.ymin), -5);

        run_tri("colin", 0, 0, 0, 1, 1, 0, 2, 2, 0, 0);
        chk("colin.drop_abs", longint'(u_if.drop_cnt), 1);
        chk("colin.kept_area", longint'(u_if.area2), 100);

        run_tri("bp", 3, -7, 100, -20, 11, 200, 15, 30, 300, 20);

        run_tri("ext", -32768, -32768, 0, 32767, -32768, -1, -32768, 32767, 32767, 0);
        chk("ext.c1_abs",   longint'(u_if.c1), -65535);
        chk("ext.area_abs", longint'(u_if.area2), 64'd4294836225);

        run_tri("vert", -3, 4, 0, -3, 9, 0, -3, -100, 0, 0);
        chk("vert.drop_abs", longint'(u_if.drop_cnt), 2);

        // Reset in the middle of MUL abandons the triangle.
        drive_tri(1, 2, 3, 40, 3, 4, 7, 50, 5, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst.out_valid",  longint'(u_if.out_valid), 0);
        chk("midrst.valid_data", longint'(u_if.valid_data), 0);
        chk("midrst.area2",      longint'(u_if.area2), 0);
        chk("midrst.c0",         longint'(u_if.c0), 0);
        chk("midrst.xmin",       longint'(u_if.xmin), 0);
        chk("midrst.z2",         longint'(u_if.z2), 0);
        chk("midrst.drop_cnt",   longint'(u_if.drop_cnt), 0);
        exp_drop = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ev = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (u_if.valid_data || u_if.out_valid) ev++;
        end
        chk("midrst.no_events", ev, 0);

        run_tri("after_rst", 1, 2, 3, 40, 3, 4, 7, 50, 5, 0);
        run_tri("colin3", 5, 5, 0, 5, 5, 0, 9, 9, 0, 0);
        chk("colin3.drop_abs", longint'(u_if.drop_cnt), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
